// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: update actions,
// direction-counter init values, and PC index/tag extraction.
package bp_pkg;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_TRAIN,
    UPD_ALLOC
  } upd_action_e;

  function automatic logic [63:0] ctr_weak_t(input int bits);
    return 64'd1 << (bits - 1);
  endfunction

  function automatic logic [63:0] ctr_weak_nt(input int bits);
    return (64'd1 << (bits - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] bp_index(input logic [63:0] pc, input int idx_bits);
    return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idx_bits,
                                         input int tag_bits);
    return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter next-value logic used to train BTB direction
// counters.
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                inc,
  output logic [CTR_BITS-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc) begin
      if (cur != '1) nxt = cur + CTR_BITS'(1);
    end else if (cur != '0) begin
      nxt = cur - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters: combinational
// IF-stage lookup, ID-stage training, misprediction detection and statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2,
  parameter int CNT_BITS = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                predict_en_i,
  input  logic                flush_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                pred_taken_o,
  output logic [XLEN-1:0]     pred_pc_o,
  input  logic                upd_valid_i,
  input  logic [XLEN-1:0]     upd_pc_i,
  input  logic                upd_pred_taken_i,
  input  logic                upd_taken_i,
  input  logic [XLEN-1:0]     upd_target_i,
  output logic                mispredict_o,
  output logic [XLEN-1:0]     redirect_pc_o,
  output logic [CNT_BITS-1:0] br_count_o,
  output logic [CNT_BITS-1:0] miss_count_o
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == '1) ? v : v + CNT_BITS'(1);
  endfunction

  entry_t              tbl_q [ENTRIES];
  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  entry_t              lk_e, up_e;
  logic                lk_hit, up_hit;
  logic [CTR_BITS-1:0] ctr_nxt;
  upd_action_e         action;
  logic [CNT_BITS-1:0] br_cnt_q, miss_cnt_q;

  assign lk_idx = IDX_BITS'(bp_index(64'(pc_i), IDX_BITS));
  assign lk_tag = TAG_BITS'(bp_tag(64'(pc_i), IDX_BITS, TAG_BITS));
  assign up_idx = IDX_BITS'(bp_index(64'(upd_pc_i), IDX_BITS));
  assign up_tag = TAG_BITS'(bp_tag(64'(upd_pc_i), IDX_BITS, TAG_BITS));

  assign lk_e   = tbl_q[lk_idx];
  assign up_e   = tbl_q[up_idx];
  assign lk_hit = lk_e.valid && (lk_e.tag == lk_tag);
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  // Lookup reads pre-update contents; the write lands at the clock edge.
  assign pred_taken_o = predict_en_i && lk_hit && lk_e.ctr[CTR_BITS-1];
  assign pred_pc_o    = pred_taken_o ? lk_e.target : pc_i + XLEN'(4);

  // A taken prediction that missed the BTB, or hit with a stale target, still redirects.
  assign mispredict_o = upd_valid_i &&
                        ((upd_pred_taken_i != upd_taken_i) ||
                         (upd_pred_taken_i && upd_taken_i &&
                          (!up_hit || (up_e.target != upd_target_i))));
  assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);

  sat_counter #(.CTR_BITS(CTR_BITS)) u_dir_ctr (
    .cur (up_e.ctr),
    .inc (upd_taken_i),
    .nxt (ctr_nxt)
  );

  always_comb begin
    action = UPD_NONE;
    if (upd_valid_i && !flush_i) begin
      if (up_hit)           action = UPD_TRAIN;
      else if (upd_taken_i) action = UPD_ALLOC;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl_q[i].valid <= 1'b0;
    end else begin
      case (action)
        UPD_TRAIN: begin
          tbl_q[up_idx].ctr <= ctr_nxt;
          if (upd_taken_i) tbl_q[up_idx].target <= upd_target_i;
        end
        UPD_ALLOC: tbl_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target_i,
                                      ctr: CTR_WEAK_T};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (upd_valid_i)  br_cnt_q   <= sat_inc(br_cnt_q);
      if (mispredict_o) miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign br_count_o   = br_cnt_q;
  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, corner
// sequences, then randomized traffic against an abstract predictor model.
module tb_branch_predictor;

  localparam int ENT = 64;
  localparam int CMAX = 15;

  logic        clk_i = 1'b0;
  logic        rst_i, predict_en_i, flush_i;
  logic [31:0] pc_i, pred_pc_o, upd_pc_i, upd_target_i, redirect_pc_o;
  logic        pred_taken_o, upd_valid_i, upd_pred_taken_i, upd_taken_i, mispredict_o;
  logic [3:0]  br_count_o, miss_count_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  branch_predictor #(
    .XLEN(32), .ENTRIES(ENT), .TAG_BITS(8), .CTR_BITS(2), .CNT_BITS(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .predict_en_i(predict_en_i), .flush_i(flush_i),
    .pc_i(pc_i), .pred_taken_o(pred_taken_o), .pred_pc_o(pred_pc_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o), .br_count_o(br_count_o), .miss_count_o(miss_count_o)
  );

  typedef struct {
    logic pen, fl, uv, upt, ut;
    logic [31:0] pc, upc, utgt;
    logic ept, emp;
    logic [31:0] eppc, erpc;
    int ebr, emiss;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic pen, logic fl, logic [31:0] pc, logic uv,
                              logic [31:0] upc, logic upt, logic ut, logic [31:0] utgt,
                              logic ept, logic [31:0] eppc, logic emp, logic [31:0] erpc,
                              int ebr, int emiss);
    vec_t v;
    v.pen = pen; v.fl = fl; v.pc = pc; v.uv = uv; v.upc = upc; v.upt = upt; v.ut = ut;
    v.utgt = utgt; v.ept = ept; v.eppc = eppc; v.emp = emp; v.erpc = erpc;
    v.ebr = ebr; v.emiss = emiss;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pen, input logic fl, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic upt,
                       input logic ut, input logic [31:0] utgt);
    predict_en_i = pen; flush_i = fl; pc_i = pc; upd_valid_i = uv; upd_pc_i = upc;
    upd_pred_taken_i = upt; upd_taken_i = ut; upd_target_i = utgt;
  endtask

  // Abstract model state: one record per BTB slot plus the two statistics.
  logic        m_valid [ENT];
  int          m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  int          m_br, m_miss;

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    logic [31:0] pc, upc, utgt, eppc, erpc;
    logic pen, fl, uv, upt, ut, ept, emp, lhit, uhit;
    int li, ui;

    rst_i = 1'b1;
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
    #2;
    check("reset_pred", 32'(pred_taken_o), 0);
    check("reset_ppc", pred_pc_o, 32'h104);
    check("reset_mp", 32'(mispredict_o), 0);
    check("reset_br", 32'(br_count_o), 0);
    check("reset_miss", 32'(miss_count_o), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    vt.push_back(mk(1,0,32'h100, 0,0,0,0,0, 0,32'h104,0,32'h4, 0,0));
    vt.push_back(mk(1,0,32'h100, 1,32'h100,0,1,32'h40, 0,32'h104,1,32'h40, 0,0));
    vt.push_back(mk(1,0,32'h100, 0,0,0,0,0, 1,32'h40,0,32'h4, 1,1));
    vt.push_back(mk(1,0,32'h100, 1,32'h100,1,1,32'h40, 1,32'h40,0,32'h40, 1,1));
    vt.push_back(mk(1,0,32'h100, 1,32'h100,1,1,32'h40, 1,32'h40,0,32'h40, 2,1));
    vt.push_back(mk(1,0,32'h100, 1,32'h100,1,0,32'h40, 1,32'h40,1,32'h104, 3,1));
    vt.push_back(mk(1,0,32'h100, 0,0,0,0,0, 1,32'h40,0,32'h4, 4,2));
    vt.push_back(mk(1,0,32'h100, 1,32'h100,1,0,32'h40, 1,32'h40,1,32'h104, 4,2));
    vt.push_back(mk(1,0,32'h100, 0,0,0,0,0, 0,32'h104,0,32'h4, 5,3));
    vt.push_back(mk(1,0,32'h100, 1,32'h100,0,1,32'h40, 0,32'h104,1,32'h40, 5,3));
    vt.push_back(mk(1,0,32'h100, 0,0,0,0,0, 1,32'h40,0,32'h4, 6,4));
    vt.push_back(mk(1,0,32'h200, 1,32'h200,0,1,32'h80, 0,32'h204,1,32'h80, 6,4));
    vt.push_back(mk(1,0,32'h100, 0,0,0,0,0, 0,32'h104,0,32'h4, 7,5));
    vt.push_back(mk(1,0,32'h200, 0,0,0,0,0, 1,32'h80,0,32'h4, 7,5));
    vt.push_back(mk(0,0,32'h200, 0,0,0,0,0, 0,32'h204,0,32'h4, 7,5));
    vt.push_back(mk(1,1,32'h200, 1,32'h300,0,1,32'hC0, 1,32'h80,1,32'hC0, 7,5));
    vt.push_back(mk(1,0,32'h300, 0,0,0,0,0, 0,32'h304,0,32'h4, 8,6));
    vt.push_back(mk(1,0,32'h200, 0,0,0,0,0, 0,32'h204,0,32'h4, 8,6));
    vt.push_back(mk(1,0,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,0,0,0, 0,32'h0,0,32'h0, 8,6));
    vt.push_back(mk(1,0,32'h104, 1,32'h104,0,1,32'h500, 0,32'h108,1,32'h500, 9,6));
    vt.push_back(mk(1,0,32'h104, 1,32'h104,1,1,32'h600, 1,32'h500,1,32'h600, 10,7));
    vt.push_back(mk(1,0,32'h104, 0,0,0,0,0, 1,32'h600,0,32'h4, 11,8));
    vt.push_back(mk(1,0,32'h104, 1,32'h404,1,1,32'h600, 1,32'h600,1,32'h600, 11,8));
    vt.push_back(mk(1,0,32'h104, 0,0,0,0,0, 0,32'h108,0,32'h4, 12,9));

    foreach (vt[i]) begin
      drive(vt[i].pen, vt[i].fl, vt[i].pc, vt[i].uv, vt[i].upc, vt[i].upt, vt[i].ut,
            vt[i].utgt);
      #2;
      check($sformatf("row%0d_pred", i), 32'(pred_taken_o), 32'(vt[i].ept));
      check($sformatf("row%0d_ppc", i), pred_pc_o, vt[i].eppc);
      check($sformatf("row%0d_mp", i), 32'(mispredict_o), 32'(vt[i].emp));
      check($sformatf("row%0d_rpc", i), redirect_pc_o, vt[i].erpc);
      check($sformatf("row%0d_br", i), 32'(br_count_o), 32'(vt[i].ebr));
      check($sformatf("row%0d_miss", i), 32'(miss_count_o), 32'(vt[i].emiss));
      @(posedge clk_i); #1;
    end

    // Statistics saturation: 16 more mispredicts must pin both counts at 15.
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 32'h8, 1, 32'h8, 1, 0, 0);
      #2;
      check("sat_mp", 32'(mispredict_o), 1);
      @(posedge clk_i); #1;
    end
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0);
    #2;
    check("sat_miss", 32'(miss_count_o), 15);
    check("sat_br", 32'(br_count_o), 15);

    // Reset asserted mid-cycle during an allocate: update lost, state cleared at once.
    @(posedge clk_i); #1;
    drive(1, 0, 32'h10, 1, 32'h10, 0, 1, 32'h70);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_br", 32'(br_count_o), 0);
    check("arst_miss", 32'(miss_count_o), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    #2;
    check("arst_pred", 32'(pred_taken_o), 0);
    check("arst_ppc", pred_pc_o, 32'h14);
    @(posedge clk_i); #1;

    // Randomized traffic against the abstract model, starting from reset state.
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_miss = 0;

    for (int n = 0; n < 1500; n++) begin
      pen  = ($urandom_range(0, 9) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      pc   = rand_pc();
      uv   = ($urandom_range(0, 2) != 0);
      upc  = rand_pc();
      ut   = 1'($urandom_range(0, 1));
      utgt = 32'h1000 + (32'($urandom_range(0, 3)) << 4);

      li   = int'(pc >> 2) % ENT;
      ui   = int'(upc >> 2) % ENT;
      lhit = m_valid[li] && (m_tag[li] == int'(pc >> 8) % 256);
      uhit = m_valid[ui] && (m_tag[ui] == int'(upc >> 8) % 256);
      if ($urandom_range(0, 1) == 1) upt = uhit && (m_ctr[ui] >= 2);
      else                           upt = 1'($urandom_range(0, 1));

      ept  = pen && lhit && (m_ctr[li] >= 2);
      eppc = ept ? m_tgt[li] : pc + 32'd4;
      emp  = uv && ((upt != ut) || (ut && upt && (!uhit || m_tgt[ui] != utgt)));
      erpc = ut ? utgt : upc + 32'd4;

      drive(pen, fl, pc, uv, upc, upt, ut, utgt);
      #2;
      check("rnd_pred", 32'(pred_taken_o), 32'(ept));
      check("rnd_ppc", pred_pc_o, eppc);
      check("rnd_mp", 32'(mispredict_o), 32'(emp));
      check("rnd_rpc", redirect_pc_o, erpc);
      check("rnd_br", 32'(br_count_o), 32'(m_br));
      check("rnd_miss", 32'(miss_count_o), 32'(m_miss));
      @(posedge clk_i); #1;

      if (uv  && m_br   < CMAX) m_br++;
      if (emp && m_miss < CMAX) m_miss++;
      if (fl) begin
        for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
      end else if (uv) begin
        if (uhit) begin
          if (ut) begin
            if (m_ctr[ui] < 3) m_ctr[ui]++;
            m_tgt[ui] = utgt;
          end else if (m_ctr[ui] > 0) begin
            m_ctr[ui]--;
          end
        end else if (ut) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = int'(upc >> 8) % 256;
          m_tgt[ui]   = utgt;
          m_ctr[ui]   = 2;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
